// File: rtl/mdu_sequencer_pkg.sv
// Shared decode constants and FSM encoding for the multiply/divide sequencer.
package mdu_sequencer_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] M_FUNCT7    = 7'b0000001;

    localparam logic [2:0] MUL_FUNCT3  = 3'b000;
    localparam logic [2:0] DIV_FUNCT3  = 3'b100;
    localparam logic [2:0] DIVU_FUNCT3 = 3'b101;
    localparam logic [2:0] REM_FUNCT3  = 3'b110;
    localparam logic [2:0] REMU_FUNCT3 = 3'b111;

    localparam int MDU_STATE_WIDTH = 2;

    typedef enum logic [MDU_STATE_WIDTH-1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // MUL plus the four divide/remainder ops; MULH* are deliberately excluded.
    function automatic logic is_m_funct3(input logic [2:0] f3);
        return (f3 == MUL_FUNCT3) || f3[2];
    endfunction

endpackage

// File: rtl/mdu_iter_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing three registers.
//   acc : product accumulator (mul) / partial remainder (div)
//   shr : multiplier shifting right (mul) / dividend->quotient shifting left (div)
//   shl : multiplicand shifting left (mul) / divisor, held (div)
module mdu_iter_datapath
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,   // multiplicand / dividend magnitude
    input  logic [XLEN-1:0] op_b,   // multiplier / divisor magnitude
    output logic [XLEN-1:0] prod,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    logic [XLEN-1:0] acc, shr, shl;
    logic [XLEN-1:0] acc_n, shr_n, shl_n;
    logic [XLEN:0]   trial;

    // Next values for one iteration of whichever algorithm is selected.
    always_comb begin
        trial = {acc, shr[XLEN-1]} - {1'b0, shl};
        acc_n = acc;
        shr_n = shr;
        shl_n = shl;
        if (is_div) begin
            // trial[XLEN] set means the subtraction borrowed: restore.
            acc_n = trial[XLEN] ? {acc[XLEN-2:0], shr[XLEN-1]} : trial[XLEN-1:0];
            shr_n = {shr[XLEN-2:0], ~trial[XLEN]};
        end else begin
            acc_n = shr[0] ? acc + shl : acc;
            shr_n = shr >> 1;
            shl_n = shl << 1;
        end
    end

    // Operand load on accept, one iteration per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            shr <= '0;
            shl <= '0;
        end else if (load) begin
            acc <= '0;
            shr <= is_div ? op_a : op_b;
            shl <= is_div ? op_b : op_a;
        end else if (step) begin
            acc <= acc_n;
            shr <= shr_n;
            shl <= shl_n;
        end
    end

    // Expose post-step values so the final iteration's result can be captured
    // on the same edge that performs it.
    assign prod = step ? acc_n : acc;
    assign quo  = step ? shr_n : shr;
    assign rem  = step ? acc_n : acc;

endmodule

// File: rtl/mdu_sequencer.sv
// EX-stage RV32M sequencer: decode, stall, iteration control and sign fixup.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    mdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_f3;
    logic             q_neg, r_neg;

    logic [2:0]       f3;
    logic             m_op, accept, sc, load, step, dp_is_div;
    logic             dec_signed, dec_div, neg_a, neg_b;
    logic [XLEN-1:0]  mag_a, mag_b, dp_a, dp_b, sc_val, fix_val;
    logic [XLEN-1:0]  dp_prod, dp_quo, dp_rem;
    logic             unused_inst;

    assign f3          = inst[14:12];
    assign unused_inst = ^{inst[24:15], inst[11:7]};

    assign m_op = inst_valid && (inst[6:0] == OPC_OP) && (inst[31:25] == M_FUNCT7)
                  && is_m_funct3(f3);

    // Operand preparation for the instruction being offered in EX.
    always_comb begin
        dec_div    = (f3 != MUL_FUNCT3);
        dec_signed = (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
        neg_a      = dec_signed && rs1_val[XLEN-1];
        neg_b      = dec_signed && rs2_val[XLEN-1];
        mag_a      = neg_a ? -rs1_val : rs1_val;
        mag_b      = neg_b ? -rs2_val : rs2_val;
        dp_a       = dec_div ? mag_a : rs1_val;
        dp_b       = dec_div ? mag_b : rs2_val;
        sc         = 1'b0;
        sc_val     = '0;
        if (dec_div && (rs2_val == '0)) begin
            sc     = 1'b1;
            sc_val = f3[1] ? rs1_val : '1;
        end else if (dec_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_val == '1)) begin
            sc     = 1'b1;
            sc_val = f3[1] ? '0 : rs1_val;
        end
    end

    // Next state and datapath control.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (m_op && !flush) begin
                    accept    = 1'b1;
                    load      = !sc;
                    state_nxt = sc ? MDU_DONE : MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (flush) begin
                    state_nxt = MDU_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) state_nxt = MDU_DONE;
                end
            end
            MDU_DONE: state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    assign dp_is_div = (state == MDU_IDLE) ? dec_div : (op_f3 != MUL_FUNCT3);

    // Final sign fixup from the latched op.
    always_comb begin
        case (op_f3)
            DIV_FUNCT3:  fix_val = q_neg ? -dp_quo : dp_quo;
            DIVU_FUNCT3: fix_val = dp_quo;
            REM_FUNCT3:  fix_val = r_neg ? -dp_rem : dp_rem;
            REMU_FUNCT3: fix_val = dp_rem;
            default:     fix_val = dp_prod;
        endcase
    end

    // State, counter, latched op and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            op_f3  <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_f3 <= f3;
                q_neg <= neg_a ^ neg_b;
                r_neg <= neg_a;
                cnt   <= CNT_W'(XLEN-1);
                if (sc) result <= sc_val;
            end
            if (step) begin
                cnt <= cnt - 1'b1;
                if (cnt == '0) result <= fix_val;
            end
        end
    end

    assign busy  = (state == MDU_CALC);
    assign done  = (state == MDU_DONE);
    assign stall = ((state == MDU_IDLE) && m_op && !flush) || (state == MDU_CALC);

    mdu_iter_datapath #(.XLEN(XLEN)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .is_div (dp_is_div),
        .op_a   (dp_a),
        .op_b   (dp_b),
        .prod   (dp_prod),
        .quo    (dp_quo),
        .rem    (dp_rem)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed checks of the multiply/divide sequencer against hand-computed values.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush;
    logic [31:0] rs1_val, rs2_val;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .flush      (flush),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        inst       = {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
        inst_valid = 1'b1;
        rs1_val    = a;
        rs2_val    = b;
    endtask

    // Offer an M-op at T0, expect done at T<lat>, then drop the instruction.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int bad;
        drive(7'b0000001, f3, a, b);
        #1;
        chk({tag, "_t0_stall"}, {31'b0, stall}, 32'd1);
        bad = 0;
        for (int i = 1; i < lat; i++) begin
            tick;
            if (!stall || !busy || done) bad++;
        end
        chk({tag, "_calc_cycles_bad"}, bad, 32'd0);
        tick;
        chk({tag, "_done"},   {31'b0, done},  32'd1);
        chk({tag, "_result"}, result,         exp);
        chk({tag, "_stall_in_done"}, {30'b0, busy, stall}, 32'd0);
        inst_valid = 1'b0;
        tick;
        chk({tag, "_after_done"}, {29'b0, done, busy, stall}, 32'd0);
        chk({tag, "_result_held"}, result, exp);
    endtask

    initial begin
        rst        = 1'b1;
        inst       = '0;
        inst_valid = 1'b0;
        flush      = 1'b0;
        rs1_val    = '0;
        rs2_val    = '0;
        tick;
        tick;
        chk("reset_outputs", {29'b0, done, busy, stall}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        tick;

        run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,       33);
        run_op("div_m20_3",   3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33);
        run_op("rem_m20_3",   3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
        run_op("divu_big_3",  3'b101, 32'hFFFFFFEC, 32'd3,        32'h5555554E, 33);
        run_op("remu_big_3",  3'b111, 32'hFFFFFFEC, 32'd3,        32'd2,        33);
        run_op("div_7_m2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_7_m2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
        run_op("mul_m1_m1",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33);
        run_op("mul_shift",   3'b000, 32'h12345678, 32'h10,       32'h23456780, 33);
        run_op("divu_min_m1", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        run_op("divu_5_0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_5_0",    3'b111, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_5_0",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_m7_0",    3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
        run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Flush mid-CALC: killed op produces no done and leaves result alone.
        begin
            int bad;
            drive(7'b0000001, 3'b000, 32'd7, 32'd6);
            #1;
            chk("flush_t0_stall", {31'b0, stall}, 32'd1);
            repeat (10) tick;
            flush = 1'b1;
            #1;
            chk("flush_t10_stall", {30'b0, busy, stall}, 32'd3);
            tick;
            flush      = 1'b0;
            inst_valid = 1'b0;
            #1;
            chk("flush_t11_idle", {29'b0, done, busy, stall}, 32'd0);
            chk("flush_result_kept", result, 32'd0);
            bad = 0;
            tick;
            if (done || busy) bad++;
            chk("flush_no_done", bad, 32'd0);
            run_op("mul_3x3_after_flush", 3'b000, 32'd3, 32'd3, 32'd9, 33);
        end

        // flush together with m_op in IDLE: no accept.
        drive(7'b0000001, 3'b000, 32'd2, 32'd2);
        flush = 1'b1;
        #1;
        chk("idle_flush_stall", {31'b0, stall}, 32'd0);
        tick;
        chk("idle_flush_no_accept", {29'b0, done, busy, stall}, 32'd0);
        flush = 1'b0;
        inst_valid = 1'b0;

        // Non-M instructions never start the block.
        drive(7'b0000000, 3'b000, 32'd2, 32'd3);
        #1;
        chk("add_stall", {31'b0, stall}, 32'd0);
        tick;
        chk("add_idle", {29'b0, done, busy, stall}, 32'd0);
        drive(7'b0000001, 3'b001, 32'd2, 32'd3);
        #1;
        chk("mulh_stall", {31'b0, stall}, 32'd0);
        tick;
        chk("mulh_idle", {29'b0, done, busy, stall}, 32'd0);
        chk("mulh_result_kept", result, 32'd9);
        inst_valid = 1'b0;
        tick;

        // Reset at T5 of a DIV discards it.
        drive(7'b0000001, 3'b100, 32'd100, 32'd7);
        repeat (5) tick;
        chk("rst_pre_busy", {31'b0, busy}, 32'd1);
        rst        = 1'b1;
        inst_valid = 1'b0;
        tick;
        rst = 1'b0;
        chk("rst_mid_outputs", {29'b0, done, busy, stall}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        repeat (40) begin
            tick;
            if (done) chk("rst_mid_no_done", {31'b0, done}, 32'd0);
        end
        chk("rst_mid_still_idle", {29'b0, done, busy, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
